// File: rtl/m_muldiv_pkg.sv
// Purpose : shared types and constants for the iterative M-extension unit.
// Latency : n/a (package only).
// Backpr. : n/a.
// Contents: muldiv_op_t (funct3 encodings), muldiv_state_t (FSM states),
//           MULDIV_FUNCT7 (funct7 that routes an R-type op to this unit).
package m_muldiv_pkg;

  // funct7 value the decoder compares against before dispatching here
  localparam logic [6:0] MULDIV_FUNCT7 = 7'b0000001;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } muldiv_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } muldiv_state_t;

endpackage

// File: rtl/m_muldiv_step.sv
// Purpose : one radix-2 iteration: shift-add for multiply, restoring
//           shift-subtract for divide, on a 2*XLEN accumulator.
// Latency : combinational.  Backpr.: none.
// Ports   : i_is_div selects the divide step; i_acc current accumulator
//           ({hi,lo}); i_b multiplicand / divisor magnitude; o_acc next value.
module m_muldiv_step
  import m_muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic                i_is_div,
  input  logic [2*XLEN-1:0]   i_acc,
  input  logic [XLEN-1:0]     i_b,
  output logic [2*XLEN-1:0]   o_acc
);

  logic [XLEN:0] w_sum;
  logic [XLEN:0] w_rem_sh;
  logic [XLEN:0] w_diff;

  always_comb begin
    // multiply: add multiplicand into the high half when the current
    // multiplier bit (lsb) is set, then shift the whole thing right
    w_sum    = {1'b0, i_acc[2*XLEN-1:XLEN]} +
               (i_acc[0] ? {1'b0, i_b} : {(XLEN+1){1'b0}});
    // divide: partial remainder after shifting in the next dividend bit.
    // remainder < divisor, so rem_sh - divisor fits XLEN+1 bits signed and
    // its msb is the borrow.
    w_rem_sh = i_acc[2*XLEN-1:XLEN-1];
    w_diff   = w_rem_sh - {1'b0, i_b};
    if (i_is_div) begin
      if (w_diff[XLEN]) begin
        o_acc = {w_rem_sh[XLEN-1:0], i_acc[XLEN-2:0], 1'b0};
      end else begin
        o_acc = {w_diff[XLEN-1:0], i_acc[XLEN-2:0], 1'b1};
      end
    end else begin
      o_acc = {w_sum, i_acc[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/m_muldiv.sv
// Purpose : iterative RV32M/RV64M multiply/divide, all eight funct3 ops.
// Latency : XLEN+2 cycles accept->done; 1 cycle for trivial cases when
//           M_MULDIV_EARLY_OUT_EN is defined.
// Backpr. : i_start only accepted in IDLE/DONE; dropped while o_busy.
// Ports   : i_clk, i_rst_n (sync, active-low), i_start, i_op (funct3),
//           i_rs1_val, i_rs2_val; o_busy (CALC/FIX), o_done (1-cycle pulse),
//           o_result (held until the next accept).
module m_muldiv
  import m_muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_start,
  input  logic [2:0]      i_op,
  input  logic [XLEN-1:0] i_rs1_val,
  input  logic [XLEN-1:0] i_rs2_val,
  output logic            o_busy,
  output logic            o_done,
  output logic [XLEN-1:0] o_result
);

  localparam int            CW   = $clog2(XLEN);
  localparam logic [CW-1:0] LAST = CW'(XLEN - 1);

  muldiv_state_t     r_state, w_next;
  muldiv_op_t        r_op, w_op;
  logic [2*XLEN-1:0] r_acc, w_acc_step;
  logic [XLEN-1:0]   r_b, r_result;
  logic [CW-1:0]     r_cnt;
  logic              r_neg;
  logic              w_accept, w_a_sgn, w_b_sgn, w_neg, w_early;
  logic [XLEN-1:0]   w_a_mag, w_b_mag, w_early_res, w_fix_res, w_q, w_r, w_hi;

  assign w_op     = muldiv_op_t'(i_op);
  assign w_accept = i_start && (r_state == ST_IDLE || r_state == ST_DONE);

  // operand magnitudes and the single sign flag FIX needs: product sign for
  // MULH/MULHSU, quotient sign for DIV, dividend sign for REM
  always_comb begin
    w_a_sgn = i_rs1_val[XLEN-1] && (w_op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM});
    w_b_sgn = i_rs2_val[XLEN-1] && (w_op inside {OP_MULH, OP_DIV, OP_REM});
    w_a_mag = w_a_sgn ? -i_rs1_val : i_rs1_val;
    w_b_mag = w_b_sgn ? -i_rs2_val : i_rs2_val;
    case (w_op)
      OP_MULH, OP_DIV:   w_neg = w_a_sgn ^ w_b_sgn;
      OP_MULHSU, OP_REM: w_neg = w_a_sgn;
      default:           w_neg = 1'b0;
    endcase
  end

`ifdef M_MULDIV_EARLY_OUT_EN
  // trivial cases resolved at accept; values match the iterative path
  always_comb begin
    w_early     = 1'b0;
    w_early_res = '0;
    if (w_op[2]) begin
      if (i_rs2_val == '0) begin
        w_early     = 1'b1;
        w_early_res = (w_op inside {OP_DIV, OP_DIVU}) ? '1 : i_rs1_val;
      end else if ((w_op inside {OP_DIV, OP_REM}) &&
                   i_rs1_val == {1'b1, {(XLEN-1){1'b0}}} && (&i_rs2_val)) begin
        w_early     = 1'b1;
        w_early_res = (w_op == OP_DIV) ? i_rs1_val : '0;
      end
    end else if (i_rs1_val == '0 || i_rs2_val == '0) begin
      w_early     = 1'b1;
      w_early_res = '0;
    end
  end
`else
  assign w_early     = 1'b0;
  assign w_early_res = '0;
`endif

  // FSM: state register
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) r_state <= ST_IDLE;
    else          r_state <= w_next;
  end

  // FSM: next state
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (i_start) w_next = w_early ? ST_DONE : ST_CALC;
      ST_CALC: if (r_cnt == LAST) w_next = ST_FIX;
      ST_FIX:  w_next = ST_DONE;
      ST_DONE: w_next = i_start ? (w_early ? ST_DONE : ST_CALC) : ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    o_busy = (r_state == ST_CALC) || (r_state == ST_FIX);
    o_done = (r_state == ST_DONE);
  end

  m_muldiv_step #(.XLEN(XLEN)) u_step (
    .i_is_div (r_op[2]),
    .i_acc    (r_acc),
    .i_b      (r_b),
    .o_acc    (w_acc_step)
  );

  // sign fix-up and result select
  always_comb begin
    w_q = r_acc[XLEN-1:0];
    w_r = r_acc[2*XLEN-1:XLEN];
    // high half of the negated 2*XLEN product: ~hi plus the carry that
    // ripples out of the low half only when the low half is zero
    w_hi = r_neg ? (~w_r + XLEN'(w_q == '0)) : w_r;
    case (r_op)
      OP_MUL:                       w_fix_res = w_q;
      OP_MULH, OP_MULHSU, OP_MULHU: w_fix_res = w_hi;
      // divisor magnitude zero forces all-ones regardless of signs
      OP_DIV, OP_DIVU:              w_fix_res = (r_b == '0) ? '1 : (r_neg ? -w_q : w_q);
      default:                      w_fix_res = r_neg ? -w_r : w_r;
    endcase
  end

  // datapath registers; multiplier / dividend start in the low half
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_op     <= OP_MUL;
      r_neg    <= 1'b0;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_b      <= '0;
      r_result <= '0;
    end else if (w_accept) begin
      r_op  <= w_op;
      r_neg <= w_neg;
      r_cnt <= '0;
      r_acc <= {{XLEN{1'b0}}, (w_op[2] ? w_a_mag : w_b_mag)};
      r_b   <= w_op[2] ? w_b_mag : w_a_mag;
      if (w_early) r_result <= w_early_res;
    end else if (r_state == ST_CALC) begin
      r_acc <= w_acc_step;
      r_cnt <= r_cnt + 1'b1;
    end else if (r_state == ST_FIX) begin
      r_result <= w_fix_res;
    end
  end

  assign o_result = r_result;

endmodule

// File: tb/tb_m_muldiv.sv
// Purpose : self-checking bench for m_muldiv (XLEN=32): directed cases,
//           handshake/reset scenarios and randomized ops vs. a reference.
// Latency : expects 34 cycles accept->done, 1 for trivial cases when
//           M_MULDIV_EARLY_OUT_EN is defined.
module tb_m_muldiv;

`ifdef M_MULDIV_EARLY_OUT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [2:0]  op;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int n_vec = 0;
  int n_err = 0;

  m_muldiv #(.XLEN(32)) dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_start   (start),
    .i_op      (op),
    .i_rs1_val (rs1),
    .i_rs2_val (rs2),
    .o_busy    (busy),
    .o_done    (done),
    .o_result  (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // reference from the architectural definition using wide arithmetic
  function automatic logic [31:0] ref_muldiv(input logic [2:0] o, input logic [31:0] a,
                                             input logic [31:0] b);
    logic signed [63:0] a_s, b_s, a_u, b_u;
    logic [63:0]        p;
    logic signed [31:0] sa, sb;
    logic               ovf;
    a_s = {{32{a[31]}}, a};
    b_s = {{32{b[31]}}, b};
    a_u = {32'b0, a};
    b_u = {32'b0, b};
    sa  = a;
    sb  = b;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (o)
      3'd0: begin p = a_u * b_u; return p[31:0]; end
      3'd1: begin p = a_s * b_s; return p[63:32]; end
      3'd2: begin p = a_s * b_u; return p[63:32]; end
      3'd3: begin p = a_u * b_u; return p[63:32]; end
      3'd4: return (b == 0) ? 32'hFFFF_FFFF : (ovf ? a : 32'(sa / sb));
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: return (b == 0) ? a : (ovf ? 32'h0 : 32'(sa % sb));
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int exp_lat(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    logic triv;
    triv = (o[2] && b == 0) ||
           ((o == 3'd4 || o == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ||
           (!o[2] && (a == 0 || b == 0));
    return (EARLY && triv) ? 1 : 34;
  endfunction

  function automatic logic [31:0] rnd_val();
    case ($urandom_range(0, 9))
      0:       return 32'h0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h1;
      4:       return 32'($urandom_range(0, 50));
      default: return $urandom;
    endcase
  endfunction

  // called from a point #1 after a rising edge with the DUT in IDLE or DONE.
  // pulse_at >= 1 drives a stray start in that cycle of the operation.
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_res, input string tag, input int pulse_at);
    int   cyc;
    logic busy_ok;
    start = 1'b1;
    op    = o;
    rs1   = a;
    rs2   = b;
    @(posedge clk); #1;
    start = 1'b0;
    op    = 3'($urandom);
    rs1   = $urandom;
    rs2   = $urandom;
    cyc     = 1;
    busy_ok = 1'b1;
    while (!done && cyc < 100) begin
      if (!busy) busy_ok = 1'b0;
      start = (cyc == pulse_at);
      @(posedge clk); #1;
      start = 1'b0;
      cyc++;
    end
    chk($sformatf("%s/lat", tag), 64'(cyc), 64'(exp_lat(o, a, b)));
    chk($sformatf("%s/res", tag), {32'b0, result}, {32'b0, exp_res});
    chk($sformatf("%s/busy_run", tag), {63'b0, busy_ok}, 64'd1);
    chk($sformatf("%s/busy_at_done", tag), {63'b0, busy}, 64'd0);
  endtask

  initial begin
    logic [2:0]  o;
    logic [31:0] a, b;
    logic        seen_done;

    rst_n = 1'b0;
    start = 1'b0;
    op    = 3'd0;
    rs1   = 32'h0;
    rs2   = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset/busy", {63'b0, busy}, 64'd0);
    chk("reset/done", {63'b0, done}, 64'd0);
    chk("reset/result", {32'b0, result}, 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // directed cases with hand-derived results
    run_op(3'd0, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, "mul_7xm3",      -1);
    run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, "mulh_minxmin",  -1);
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, "mulhu_max",     -1);
    run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhsu_m1",     -1);
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, "div_m7_2",      -1);
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, "rem_m7_2",      -1);
    run_op(3'd5, 32'hFFFF_FFF9, 32'd2,        32'h7FFF_FFFC, "divu_2",        -1);
    run_op(3'd5, 32'd5,        32'd0,        32'hFFFF_FFFF, "divu_by0",      -1);
    run_op(3'd7, 32'd5,        32'd0,        32'd5,         "remu_by0",      -1);
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, "div_ovf",      -1);
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,        "rem_ovf",       -1);
    run_op(3'd4, 32'hFFFF_FFF9, 32'd0,        32'hFFFF_FFFF, "div_neg_by0",   -1);
    run_op(3'd6, 32'hFFFF_FFF9, 32'd0,        32'hFFFF_FFF9, "rem_neg_by0",   -1);

    // stray start during CALC is ignored; the next op is launched in the
    // DONE cycle of this one (start held through DONE)
    run_op(3'd0, 32'd12345,    32'd678,      32'd8369910,   "mul_ignore_st", 10);
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, "b2b_second",   -1);

    // reset in the middle of CALC abandons the op
    start = 1'b1;
    op    = 3'd0;
    rs1   = 32'd9;
    rs2   = 32'd11;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (19) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("midreset/busy", {63'b0, busy}, 64'd0);
    chk("midreset/result", {32'b0, result}, 64'd0);
    rst_n = 1'b1;
    seen_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done) seen_done = 1'b1;
      @(posedge clk); #1;
    end
    chk("midreset/no_done", {63'b0, seen_done}, 64'd0);
    run_op(3'd0, 32'd9, 32'd11, 32'd99, "after_reset", -1);

    // randomized ops against the reference model
    for (int i = 0; i < 200; i++) begin
      o = 3'($urandom_range(0, 7));
      a = rnd_val();
      b = rnd_val();
      run_op(o, a, b, ref_muldiv(o, a, b), $sformatf("rnd%0d_op%0d", i, o), -1);
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
